sseg_scan_mux: RTL and testbench



---
 rtl/sseg_pkg.sv | 23 ++
 rtl/sseg_slot_timer.sv | 65 ++++++
 rtl/sseg_scan_mux.sv | 131 +++++++++++++
 tb/tb_sseg_scan_mux.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
// Optional leading-zero blanking in sseg_scan_mux is enabled by SSEG_LEADING_ZERO_BLANK_EN.
package sseg_pkg;

  localparam int MAX_DIGITS       = 8;
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_BLANK_CYCLES = 500;

  typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

  localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

  typedef enum logic {
    S_BLANK,
    S_ON
  } state_e;

  // A single-digit display still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot counter, blank/on FSM and digit index for the display scanner.
// Exposes the next index so the owner can register data alongside it.
module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int CW           = $clog2(SLOT_CYCLES),
  localparam int IW           = idx_w(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output state_e        state,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] idx_nxt,
  output logic          boundary
);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wrap;
  state_e        state_nxt;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == IDX_LAST);

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    if (wrap) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_BLANK;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BLANK: if (cnt == CNT_BLANK) state_nxt = S_ON;
      S_ON:    if (wrap)             state_nxt = S_BLANK;
      default:                       state_nxt = S_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed LED digit scanner with tear-free frame shadowing.
// Define SSEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] frame_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              hex,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    upd_done
);

  localparam int IW = idx_w(NUM_DIGITS);

  state_e          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic            boundary;

  logic [NUM_DIGITS-1:0][3:0] pend_frame;
  logic [NUM_DIGITS-1:0]      pend_dp;
  logic                       pend_vld;
  logic [NUM_DIGITS-1:0][3:0] shd_frame;
  logic [NUM_DIGITS-1:0]      shd_dp;
  logic [NUM_DIGITS-1:0][3:0] shd_frame_nxt;
  logic [NUM_DIGITS-1:0]      shd_dp_nxt;
  logic                       shd_wr;
  logic                       digit_en;

  sseg_slot_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .state    (state),
    .idx      (idx),
    .idx_nxt  (idx_nxt),
    .boundary (boundary)
  );

  // A load landing on the boundary bypasses pending so it is not lost a frame.
  always_comb begin
    shd_wr        = 1'b0;
    shd_frame_nxt = shd_frame;
    shd_dp_nxt    = shd_dp;
    if (boundary && load) begin
      shd_wr        = 1'b1;
      shd_frame_nxt = frame_in;
      shd_dp_nxt    = dp_in;
    end else if (boundary && pend_vld) begin
      shd_wr        = 1'b1;
      shd_frame_nxt = pend_frame;
      shd_dp_nxt    = pend_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_frame <= '0;
      pend_dp    <= '0;
      pend_vld   <= 1'b0;
      shd_frame  <= '0;
      shd_dp     <= '0;
      upd_done   <= 1'b0;
    end else begin
      shd_frame <= shd_frame_nxt;
      shd_dp    <= shd_dp_nxt;
      upd_done  <= shd_wr;
      if (load) begin
        pend_frame <= frame_in;
        pend_dp    <= dp_in;
      end
      if (shd_wr)    pend_vld <= 1'b0;
      else if (load) pend_vld <= 1'b1;
    end
  end

  // Data follows the next index so the decoder settles during the blank.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex <= 4'h0;
      dp  <= 1'b0;
    end else begin
      hex <= shd_frame_nxt[idx_nxt];
      dp  <= shd_dp_nxt[idx_nxt];
    end
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;

  // Blank from the top down while digits are zero; a set dp ends the run.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [NUM_DIGITS-1:0][3:0] f,
    input logic [NUM_DIGITS-1:0]      d
  );
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run        = run && (f[i] == 4'h0) && !d[i];
      lz_mask[i] = run;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset)       blank_mask <= '0;
    else if (shd_wr) blank_mask <= lz_mask(shd_frame_nxt, shd_dp_nxt);
  end

  assign digit_en = ~blank_mask[idx];
`else
  assign digit_en = 1'b1;
`endif

  always_comb begin
    an = AN_ALL_OFF[NUM_DIGITS-1:0];
    if (state == S_ON && digit_en) an[idx] = 1'b0;
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with 4 digits, 8-cycle slots, 2-cycle blank.
// Leading-zero blanking vectors run when SSEG_LEADING_ZERO_BLANK_EN is defined.
module tb_sseg_scan_mux;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] frame_in;
  logic [3:0]  dp_in;
  logic [3:0]  hex;
  logic        dp;
  logic [3:0]  an;
  logic        upd_done;

  int n_chk;
  int n_fail;
  int fno;

  sseg_scan_mux #(
    .NUM_DIGITS   (4),
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .frame_in (frame_in),
    .dp_in    (dp_in),
    .hex      (hex),
    .dp       (dp),
    .an       (an),
    .upd_done (upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks ncyc cycles from frame cycle 0, checking outputs against the
  // frame f/d expected on display and driving up to two loads.
  task automatic run_frame(
    input int ncyc, input logic [15:0] f, input logic [3:0] d,
    input logic [3:0] m, input bit upd0,
    input int la0, input logic [15:0] lf0, input logic [3:0] ld0,
    input int la1, input logic [15:0] lf1, input logic [3:0] ld1
  );
    for (int k = 0; k < ncyc; k++) begin
      int s;
      logic [3:0] ea;
      logic [3:0] eh;
      s  = k / 8;
      ea = 4'hF;
      if ((k % 8) >= 2 && !m[s]) ea[s] = 1'b0;
      eh = f[4*s +: 4];
      chk($sformatf("an f%0d k%0d", fno, k), 32'(an), 32'(ea));
      chk($sformatf("hex f%0d k%0d", fno, k), 32'(hex), 32'(eh));
      chk($sformatf("dp f%0d k%0d", fno, k), 32'(dp), 32'(d[s]));
      chk($sformatf("upd f%0d k%0d", fno, k), 32'(upd_done), 32'(upd0 && k == 0));
      load = 1'b0;
      if (k == la0) begin load = 1'b1; frame_in = lf0; dp_in = ld0; end
      if (k == la1) begin load = 1'b1; frame_in = lf1; dp_in = ld1; end
      step();
    end
    load = 1'b0;
    fno++;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    fno      = 0;
    reset    = 1'b1;
    load     = 1'b0;
    frame_in = 16'h0;
    dp_in    = 4'h0;
    @(negedge clk);
    step();
    step();
    chk("rst an",  32'(an),       32'hF);
    chk("rst hex", 32'(hex),      32'h0);
    chk("rst dp",  32'(dp),       32'h0);
    chk("rst upd", 32'(upd_done), 32'h0);
    reset = 1'b0;

    // idle scan, then single load at cycle 5
    run_frame(32, 16'h0000, 4'b0000, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame(32, 16'h0000, 4'b0000, 4'b0000, 1'b0,  5, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    // new frame visible; two loads, last wins
    run_frame(32, 16'h1234, 4'b0100, 4'b0000, 1'b1,  3, 16'hAAAA, 4'b0000, 20, 16'h5678, 4'b0011);
    // load coincident with the boundary cycle
    run_frame(32, 16'h5678, 4'b0011, 4'b0000, 1'b1, 31, 16'h9ABC, 4'b1000, -1, 16'h0, 4'h0);
    run_frame(32, 16'h9ABC, 4'b1000, 4'b0000, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // reset during digit 2 ON with a load pending
    run_frame(19, 16'h9ABC, 4'b1000, 4'b0000, 1'b0,  3, 16'h1111, 4'b1111, -1, 16'h0, 4'h0);
    reset = 1'b1;
    step();
    chk("midrst an",  32'(an),       32'hF);
    chk("midrst hex", 32'(hex),      32'h0);
    chk("midrst dp",  32'(dp),       32'h0);
    chk("midrst upd", 32'(upd_done), 32'h0);
    reset = 1'b0;
    run_frame(32, 16'h0000, 4'b0000, 4'b0000, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame(32, 16'h0000, 4'b0000, 4'b0000, 1'b0,  4, 16'h0040, 4'b0000, -1, 16'h0, 4'h0);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    run_frame(32, 16'h0040, 4'b0000, 4'b1100, 1'b1, 10, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
    run_frame(32, 16'h0000, 4'b0000, 4'b1110, 1'b1, 12, 16'h0005, 4'b0100, -1, 16'h0, 4'h0);
    run_frame(32, 16'h0005, 4'b0100, 4'b1000, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
`else
    run_frame(32, 16'h0040, 4'b0000, 4'b0000, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
